lcd_bus_arb: RTL

LCD_BUS_ARB -- requirements
Module: lcd_bus_arb

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_rr_arb.sv | 31 +++
 rtl/lcd_bus_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit LCD bus arbiter: FSM encoding, default timing and
// LCD command codes whose execution needs the long settle delay.
package lcd_pkg;

  localparam int unsigned T_SETUP_DEF = 10;
  localparam int unsigned T_EN_DEF    = 50;
  localparam int unsigned T_NIB_DEF   = 100;
  localparam int unsigned T_CMD_DEF   = 5000;
  localparam int unsigned T_LONG_DEF  = 200000;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP_HI = 3'd1;
  localparam logic [2:0] ST_EN_HI    = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_SETUP_LO = 3'd4;
  localparam logic [2:0] ST_EN_LO    = 3'd5;
  localparam logic [2:0] ST_POST     = 3'd6;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear and home are the only commands the controller executes slowly.
  function automatic logic is_long_cmd(input logic [7:0] b, input logic rs);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the loser on each update.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  // r_ptr = 1 means requester 1 wins a tie.
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_update && (o_grant != 2'b00)) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/lcd_bus_arb.sv
// Arbitrates two byte writers onto an HD44780-style 4-bit LCD bus with timed nibble strobes.
// Optional macro LCD_ARB_LONG_CMD_EN: clear/home commands use the T_LONG settle delay.
module lcd_bus_arb
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EN    = T_EN_DEF,
  parameter int unsigned T_NIB   = T_NIB_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_LONG  = T_LONG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] byte0,
  input  logic       rs0,
  input  logic [7:0] byte1,
  input  logic       rs1,
  output logic [1:0] ack,
  output logic       busy,
  output logic [3:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  // Counter only ever holds N-1 of the largest delay.
  localparam int unsigned T_MAX =
    max_u(max_u(max_u(T_SETUP, T_EN), max_u(T_NIB, T_CMD)), T_LONG);
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_NIB   = CNT_W'(T_NIB - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_byte;
  logic             r_rs;
  logic [3:0]       r_data;
  logic             r_lcd_rs;
  logic             r_en;

  logic [1:0]       w_grant;
  logic [1:0]       w_ack;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_post_ld;
  logic [7:0]       w_byte_sel;
  logic             w_rs_sel;
  logic [7:0]       w_byte_cur;
  logic             w_rs_cur;

  lcd_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_update (w_ack != 2'b00),
    .o_grant  (w_grant)
  );

  // Gating with rst keeps a requester from seeing an ack for a byte that reset discards.
  assign w_ack      = (!rst && (r_state == ST_IDLE)) ? w_grant : 2'b00;
  assign w_byte_sel = w_ack[1] ? byte1 : byte0;
  assign w_rs_sel   = w_ack[1] ? rs1 : rs0;
  assign w_byte_cur = (w_ack != 2'b00) ? w_byte_sel : r_byte;
  assign w_rs_cur   = (w_ack != 2'b00) ? w_rs_sel : r_rs;

`ifdef LCD_ARB_LONG_CMD_EN
  localparam logic [CNT_W-1:0] LD_LONG = CNT_W'(T_LONG - 1);
  assign w_post_ld = is_long_cmd(r_byte, r_rs) ? LD_LONG : LD_CMD;
`else
  assign w_post_ld = LD_CMD;
`endif

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == ST_IDLE) begin
      if (w_ack != 2'b00) begin
        w_state_nxt = ST_SETUP_HI;
        w_cnt_nxt   = LD_SETUP;
      end
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end else begin
      case (r_state)
        ST_SETUP_HI: begin w_state_nxt = ST_EN_HI;    w_cnt_nxt = LD_EN;     end
        ST_EN_HI:    begin w_state_nxt = ST_GAP;      w_cnt_nxt = LD_NIB;    end
        ST_GAP:      begin w_state_nxt = ST_SETUP_LO; w_cnt_nxt = LD_SETUP;  end
        ST_SETUP_LO: begin w_state_nxt = ST_EN_LO;    w_cnt_nxt = LD_EN;     end
        ST_EN_LO:    begin w_state_nxt = ST_POST;     w_cnt_nxt = w_post_ld; end
        default:     begin w_state_nxt = ST_IDLE;     w_cnt_nxt = '0;        end
      endcase
    end
  end

  // Bus outputs are decoded from the next state so they change on the same edge as the FSM.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_rs     <= 1'b0;
      r_data   <= '0;
      r_lcd_rs <= 1'b0;
      r_en     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_ack != 2'b00) begin
        r_byte <= w_byte_sel;
        r_rs   <= w_rs_sel;
      end
      r_en <= (w_state_nxt == ST_EN_HI) || (w_state_nxt == ST_EN_LO);
      case (w_state_nxt)
        ST_SETUP_HI, ST_EN_HI, ST_GAP:   r_data <= w_byte_cur[7:4];
        ST_SETUP_LO, ST_EN_LO, ST_POST:  r_data <= r_byte[3:0];
        default:                         r_data <= r_data;
      endcase
      if (w_state_nxt != ST_IDLE) begin
        r_lcd_rs <= w_rs_cur;
      end
    end
  end

  assign ack      = w_ack;
  assign busy     = (r_state != ST_IDLE);
  assign lcd_data = r_data;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = r_en;

endmodule
